shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Parametrised sequential shift-add multiplier, the successor to the fixed 8-bit lab multiplier. It accepts two WIDTH-bit operands on a Start request and computes one partial-product iteration per clock. It supports signed (two's complement) and unsigned modes and signals completion with a one-cycle Done pulse. It sits between the synchronised switch/button front end and the hex display drivers, and also serves as a reusable datapath block for later labs.

## Interface
- WIDTH, 8: operand width in bits; legal range 2–32.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state on the next edge.
- Start  in  1  level request; sampled only in IDLE or DONE.
- Signed_Mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- Multiplicand  in  WIDTH  operand M; sampled with Start.
- Multiplier  in  WIDTH  operand Q; sampled with Start.
- Busy  out  1  high while iterating (state CALC).
- Done  out  1  high for exactly one cycle (state DONE) when Product is final.
- Product  out  2*WIDTH  {Aval, Bval}; final from DONE until the next accepted Start.
- Aval  out  WIDTH  upper accumulator register A.
- Bval  out  WIDTH  lower register B (multiplier, shifted out as product bits arrive).
- X  out  1  extension bit above A.

## Operation
- Registers: A, B, M (WIDTH each), X (1), mode flag, iteration counter (clog2(WIDTH) bits), state.
- States: IDLE, CALC, DONE.
  - IDLE --Start--> CALC.
  - CALC --(count == WIDTH-1)--> DONE.
  - DONE --Start--> CALC; otherwise DONE --> IDLE.
- Load (edge on which Start is accepted):
  - M ← Multiplicand, B ← Multiplier.
  - A ← 0, X ← 0, count ← 0.
  - mode flag ← Signed_Mode.
- Iteration (every CALC edge):
  - If B[0] = 1, S = ext(A) ± ext(M), computed at WIDTH+1 bits. Otherwise S = {X, A}.
  - Subtract only when the mode flag is signed and count == WIDTH-1. All other iterations add.
  - ext() is sign extension in signed mode and zero extension in unsigned mode.
  - In the same edge, {X, A, B} ← {S[WIDTH] or replicated sign, S[WIDTH:0], B[WIDTH-1:1]}.
    - This is a right shift by one.
    - The new X is S[WIDTH] (the sign copy) in signed mode, and 0 in unsigned mode.
    - The carry S[WIDTH] enters A's MSB.
  - count ← count + 1.
- Start is ignored in CALC. Operands may change freely after the load edge.
- Start held high continuously restarts a new multiply on every DONE cycle (back-to-back operation).
- Reset:
  - A, B, M, X, count ← 0; state ← IDLE.
  - Busy, Done = 0; Product = 0.
  - Reset has priority over Start and over an in-flight CALC.
- In IDLE, A, B and X hold, so the last Product stays readable.

## Timing
- Start accepted on edge t → Busy high for cycles t+1 … t+WIDTH.
- Done is high in cycle t+WIDTH+1 only. Total latency is WIDTH+1 cycles from the accepting edge to Done.
- Product shows working registers while Busy and is valid only when Done is high and after that.
- Busy and Done are never high together. Both decode directly from the state register, with no combinational path from the inputs.
- Reset asserted during CALC: Busy = 0 in the cycle after that edge; no Done pulse is produced.

## Structure
- Package mult_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, CALC, DONE});
  - a function returning the counter width, clog2(WIDTH).
- One sub-module, mult_addsub:
  - WIDTH+1-bit adder/subtractor with signed/zero extension select;
  - purely combinational;
  - instantiated once.
- The FSM, counter and shift registers live in the top level.

## Test plan
- WIDTH=8, signed, 0xFE × 0x03 → Done at cycle 9 after the load edge; Product = 0xFFFA.
- WIDTH=8, unsigned, 0xFE × 0x03 → Product = 0x02FA. Also 0xFF × 0xFF unsigned → 0xFE01, and signed → 0x0001.
- WIDTH=8, signed, 0x80 × 0x80 → Product = 0x4000 (last-iteration subtract with most-negative operands).
- WIDTH=16, signed, 0x8000 × 0x7FFF → Product = 0xC0008000. Busy high for exactly 16 cycles.
- Start held high for 3 operations → three Done pulses spaced WIDTH+1 cycles apart. Operands changed mid-CALC do not affect the result.
- Reset asserted at iteration 4 → next cycle state IDLE with Busy = 0, Done = 0, Product = 0. A following Start gives a correct result.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; a 1-bit minimum keeps degenerate widths legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_addsub.sv
// WIDTH+1-bit adder/subtractor; operands are sign- or zero-extended by one bit.
module mult_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;

  // Extend both operands, then add or subtract at full WIDTH+1 precision.
  always_comb begin
    w_a   = {i_signed & i_a[WIDTH-1], i_a};
    w_b   = {i_signed & i_b[WIDTH-1], i_b};
    o_sum = i_sub ? (w_a - w_b) : (w_a + w_b);
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: one partial product per clock, signed or unsigned.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [WIDTH-1:0]     Aval,
  output logic [WIDTH-1:0]     Bval,
  output logic                 X
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_x;
  logic             r_signed;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_s;

  assign w_last = (r_cnt == LAST);
  // The multiplier's MSB carries negative weight in two's complement.
  assign w_sub  = r_signed & w_last;
  assign w_s    = r_b[0] ? w_sum : {r_x, r_a};

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a      (r_a),
    .i_b      (r_m),
    .i_sub    (w_sub),
    .i_signed (r_signed),
    .o_sum    (w_sum)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and operand-load strobe.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: if (Start) begin
        w_next = CALC;
        w_load = 1'b1;
      end
      CALC: if (w_last) w_next = DONE;
      DONE: begin
        if (Start) begin
          w_next = CALC;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load operands, then shift {X, A, B} right once per CALC cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_x      <= 1'b0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a      <= '0;
      r_b      <= Multiplier;
      r_m      <= Multiplicand;
      r_x      <= 1'b0;
      r_signed <= Signed_Mode;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      r_x      <= r_signed & w_s[WIDTH];
      r_a      <= w_s[WIDTH:1];
      r_b      <= {w_s[0], r_b[WIDTH-1:1]};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign Busy    = (r_state == CALC);
  assign Done    = (r_state == DONE);
  assign Product = {r_a, r_b};
  assign Aval    = r_a;
  assign Bval    = r_b;
  assign X       = r_x;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult (WIDTH=8 and WIDTH=16 instances).
module tb_shift_add_mult;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        start8, sm8;
  logic [7:0]  mc8, mp8;
  logic        busy8, done8, x8;
  logic [15:0] prod8;
  logic [7:0]  a8, b8;

  logic        start16, sm16;
  logic [15:0] mc16, mp16;
  logic        busy16, done16, x16;
  logic [31:0] prod16;
  logic [15:0] a16, b16;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        sgn;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  shift_add_mult #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Signed_Mode(sm8),
    .Multiplicand(mc8), .Multiplier(mp8), .Busy(busy8), .Done(done8),
    .Product(prod8), .Aval(a8), .Bval(b8), .X(x8)
  );

  shift_add_mult #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(rst), .Start(start16), .Signed_Mode(sm16),
    .Multiplicand(mc16), .Multiplier(mp16), .Busy(busy16), .Done(done16),
    .Product(prod16), .Aval(a16), .Bval(b16), .X(x16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs one multiply on the 8-bit instance, scrambling inputs after the load edge.
  task automatic run8(input string name, input logic sgn, input logic [7:0] m,
                      input logic [7:0] q, input logic [15:0] exp);
    int k;
    int nb;
    bit seen;
    bit overlap;
    @(negedge clk);
    start8 = 1'b1; sm8 = sgn; mc8 = m; mp8 = q;
    @(posedge clk);
    #1;
    start8 = 1'b0; sm8 = ~sgn; mc8 = 8'($urandom); mp8 = 8'($urandom);
    k = 0; nb = 0; seen = 1'b0; overlap = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) seen = 1'b1;
      else if (busy8) nb++;
    end
    check({name, "_latency"}, 64'(k), 64'd9);
    check({name, "_busy_cycles"}, 64'(nb), 64'd8);
    check({name, "_no_overlap"}, 64'(overlap), 64'd0);
    check({name, "_product"}, 64'(prod8), 64'(exp));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'({busy8, done8}), 64'd0);
    check({name, "_held"}, 64'(prod8), 64'(exp));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
    vecs[1]  = '{1'b0, 8'hFE, 8'h03, 16'h02FA};
    vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[3]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[4]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[5]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[6]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[7]  = '{1'b0, 8'h00, 8'h5A, 16'h0000};
    vecs[8]  = '{1'b1, 8'h05, 8'hFB, 16'hFFE7};
    vecs[9]  = '{1'b0, 8'h0F, 8'h11, 16'h00FF};
    vecs[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[11] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
    start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done", 64'({busy8, done8}), 64'd0);
    check("reset_product", 64'(prod8), 64'd0);
    check("reset_x", 64'(x8), 64'd0);
    check("reset_product16", 64'(prod16), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run8($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].m, vecs[i].q, vecs[i].exp);

    // 16-bit: most-negative times most-positive, busy exactly 16 cycles.
    begin
      int k;
      int nb;
      bit seen;
      @(negedge clk);
      start16 = 1'b1; sm16 = 1'b1; mc16 = 16'h8000; mp16 = 16'h7FFF;
      @(posedge clk);
      #1;
      start16 = 1'b0; mc16 = 16'h1234; mp16 = 16'hABCD;
      k = 0; nb = 0; seen = 1'b0;
      while (!seen && k < 60) begin
        @(negedge clk);
        k++;
        if (done16) seen = 1'b1;
        else if (busy16) nb++;
      end
      check("w16_latency", 64'(k), 64'd17);
      check("w16_busy_cycles", 64'(nb), 64'd16);
      check("w16_product", 64'(prod16), 64'hC0008000);
    end

    // Start held high: three back-to-back multiplies, operands scrambled mid-CALC.
    begin
      logic [7:0]  bm[3];
      logic [7:0]  bq[3];
      logic        bs[3];
      logic [15:0] be[3];
      int          last_cyc;
      int          k;
      bit          seen;
      bm[0] = 8'hFE; bq[0] = 8'h03; bs[0] = 1'b1; be[0] = 16'hFFFA;
      bm[1] = 8'hFF; bq[1] = 8'hFF; bs[1] = 1'b0; be[1] = 16'hFE01;
      bm[2] = 8'h80; bq[2] = 8'h80; bs[2] = 1'b1; be[2] = 16'h4000;
      last_cyc = 0;
      @(negedge clk);
      start8 = 1'b1; sm8 = bs[0]; mc8 = bm[0]; mp8 = bq[0];
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
          @(negedge clk);
          k++;
          if (done8) seen = 1'b1;
          else begin
            mc8 = 8'($urandom); mp8 = 8'($urandom); sm8 = 1'($urandom);
          end
        end
        check($sformatf("b2b%0d_done", i), 64'(seen), 64'd1);
        check($sformatf("b2b%0d_product", i), 64'(prod8), 64'(be[i]));
        if (i > 0) check($sformatf("b2b%0d_spacing", i), 64'(cyc - last_cyc), 64'd9);
        last_cyc = cyc;
        if (i < 2) begin
          sm8 = bs[i+1]; mc8 = bm[i+1]; mp8 = bq[i+1];
        end else begin
          start8 = 1'b0;
        end
        @(posedge clk);
      end
      @(negedge clk);
      check("b2b_end_idle", 64'({busy8, done8}), 64'd0);
    end

    // Reset at iteration 4 aborts the multiply with no Done pulse.
    begin
      bit saw_done;
      @(negedge clk);
      start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h05; mp8 = 8'hFB;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pre_reset_busy", 64'(busy8), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy_done", 64'({busy8, done8}), 64'd0);
      check("abort_product", 64'(prod8), 64'd0);
      saw_done = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (done8 || busy8) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
    end
    run8("after_reset", 1'b1, 8'h05, 8'hFB, 16'hFFE7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
